useq_mbox: RTL and testbench
============================

// Module: useq_mbox
// PURPOSE
//   Multi-channel message mailbox for useq-based designs: CHANNELS independent
//   FIFOs of WIDTH x DEPTH. A producer pushes and a consumer pops on each channel.
//   Adds what the single embedded useq FIFO lacks: simultaneous push/pop,
//   per-channel level IRQ, and sticky overflow/underflow flags.
//   Sits between a host fabric and one or more useq cores.
// PARAMETERS
//   WIDTH    8          data bits per entry
//   DEPTH    16         entries per channel; power of 2, >= 2
//   CHANNELS 4          number of independent FIFOs, >= 1
//   THRESH   DEPTH/2    level IRQ fires when count >= THRESH; 1..DEPTH
// PORTS
//   clk        in   1               clock, all logic on rising edge
//   rst_n      in   1               asynchronous active-low reset
//   wr_en      in   CHANNELS        push request, per channel
//   wr_data    in   CHANNELS*WIDTH  push data; channel c at [c*WIDTH +: WIDTH]
//   rd_en      in   CHANNELS        pop request, per channel
//   rd_data    out  CHANNELS*WIDTH  registered pop data, same packing as wr_data
//   rd_valid   out  CHANNELS        1-cycle pulse: rd_data for that channel updated
//   full       out  CHANNELS        count == DEPTH
//   empty      out  CHANNELS        count == 0
//   count      out  CHANNELS*CW     occupancy per channel; CW = $clog2(DEPTH)+1
//   irq_mask   in   CHANNELS        1 enables that channel's level IRQ
//   irq        out  1               registered OR of masked level hits
//   err_ovf    out  CHANNELS        sticky: push rejected
//   err_unf    out  CHANNELS        sticky: pop rejected
//   err_clr    in   CHANNELS        clears err_ovf/err_unf of that channel
// BEHAVIOUR
//   Reset (async, rst_n=0): pointers, count, rd_data, rd_valid, irq, err_* <= 0;
//     empty = all 1, full = all 0. Storage array is NOT reset (RAM inference).
//     Reset mid-operation discards all queued data immediately; first valid
//     push is allowed on the first rising edge after rst_n deasserts.
//   Channels are fully independent; the rules below apply per channel c.
//   pop_ok  = rd_en & (count != 0)
//   push_ok = wr_en & ((count != DEPTH) | pop_ok)
//     (Full + both: both accepted. Empty + both: push accepted, pop rejected.)
//   Pop: rd_data <= mem[rptr] and rd_valid <= 1 on the accepting edge.
//     Data is visible the cycle after rd_en (1-cycle latency).
//     rptr <= rptr+1, wrapping mod DEPTH.
//   Rejected pop: rd_data holds its previous value; rd_valid <= 0; err_unf <= 1.
//   Push: mem[wptr] <= wr_data; wptr <= wptr+1, wrapping mod DEPTH.
//   Rejected push: data dropped; err_ovf <= 1.
//   count <= count + push_ok - pop_ok; never exceeds DEPTH or goes below 0.
//   full/empty/count are combinational from registered count (no extra delay).
//   level[c] = count[c] >= THRESH; irq <= |(level & irq_mask), 1 cycle after count.
//   err_clr: clears that channel's sticky bits next edge; if an error event
//     occurs in the same cycle, set wins.
//   No state machine beyond the pointers/counters; no cross-channel interaction.
// TESTING
//   Default params. Push 0x11..0x14 on ch0, then pop 4 -> rd_data 0x11..0x14 in
//     order, each one cycle after rd_en with rd_valid=1; ch1..3 stay empty.
//   Fill ch2 with 16 pushes -> full[2]=1, count=16. 17th push -> err_ovf[2]=1, no
//     count change. Pop 16 -> original data order, despite pointer wrap.
//   ch1 full, push 0xAA + pop same cycle -> count stays 16, pop returns oldest,
//     0xAA is last out. ch3 empty, push+pop -> count=1, err_unf[3]=1,
//     rd_valid[3]=0.
//   irq_mask=4'b0001: push 8 into ch0 -> irq=1 the cycle after count hits 8;
//     pop 1 -> irq=0 next cycle. ch1 reaching 8 with mask bit 0 -> irq stays 0.
//   Set err_unf[0], pulse err_clr[0] alone -> cleared. err_clr[0] + empty pop
//     same cycle -> err_unf[0] stays 1.
//   Drop rst_n asynchronously mid-burst with ch0 count=5 -> outputs zero before
//     the next edge, empty=4'hF. After release, first push/pop behave as fresh.

Source files
------------

// File: rtl/useq_mbox_if.sv
// -----------------------------------------------------------------------------
// useq_mbox_if
//   Bundles every per-channel mailbox signal except clock and reset.
//   master : producer/consumer side (host fabric or testbench)
//   slave  : the mailbox itself
//   Signals (all packed per channel, channel c at [c*W +: W]):
//     wr_en, wr_data       push request / push data
//     rd_en                pop request
//     rd_data, rd_valid    registered pop data and its 1-cycle update pulse
//     full, empty, count   occupancy status
//     irq_mask, irq        level IRQ enables and the combined interrupt
//     err_ovf, err_unf     sticky push/pop rejection flags
//     err_clr              clears the sticky flags of a channel
// -----------------------------------------------------------------------------
interface useq_mbox_if #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]       wr_en;
    logic [CHANNELS*WIDTH-1:0] wr_data;
    logic [CHANNELS-1:0]       rd_en;
    logic [CHANNELS*WIDTH-1:0] rd_data;
    logic [CHANNELS-1:0]       rd_valid;
    logic [CHANNELS-1:0]       full;
    logic [CHANNELS-1:0]       empty;
    logic [CHANNELS*CW-1:0]    count;
    logic [CHANNELS-1:0]       irq_mask;
    logic                      irq;
    logic [CHANNELS-1:0]       err_ovf;
    logic [CHANNELS-1:0]       err_unf;
    logic [CHANNELS-1:0]       err_clr;

    modport master (
        output wr_en, wr_data, rd_en, irq_mask, err_clr,
        input  rd_data, rd_valid, full, empty, count, irq, err_ovf, err_unf
    );

    modport slave (
        input  wr_en, wr_data, rd_en, irq_mask, err_clr,
        output rd_data, rd_valid, full, empty, count, irq, err_ovf, err_unf
    );
endinterface

// File: rtl/useq_mbox.sv
// -----------------------------------------------------------------------------
// useq_mbox
//   CHANNELS independent WIDTH x DEPTH FIFOs with simultaneous push/pop,
//   a masked level interrupt and sticky overflow/underflow flags.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave side of useq_mbox_if (push/pop, status, irq, errors)
//   Storage is deliberately left unreset so it can map onto RAM.
// -----------------------------------------------------------------------------
module useq_mbox #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 4,
    parameter int THRESH   = DEPTH / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    useq_mbox_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [AW-1:0]       wptr_q  [CHANNELS];
    logic [AW-1:0]       wptr_d  [CHANNELS];
    logic [AW-1:0]       rptr_q  [CHANNELS];
    logic [AW-1:0]       rptr_d  [CHANNELS];
    logic [WIDTH-1:0]    rdat_q  [CHANNELS];
    logic [WIDTH-1:0]    rdat_d  [CHANNELS];
    logic [WIDTH-1:0]    mem_q   [CHANNELS][DEPTH];
    logic [CHANNELS-1:0] rvld_q, rvld_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] unf_q, unf_d;
    logic [CHANNELS-1:0] push_ok_s, pop_ok_s, level_s;
    logic                irq_q, irq_d;

    // Per-channel accept decisions and next-state for pointers, count, data, flags.
    always_comb begin
        push_ok_s = {CHANNELS{1'b0}};
        pop_ok_s  = {CHANNELS{1'b0}};
        level_s   = {CHANNELS{1'b0}};
        rvld_d    = {CHANNELS{1'b0}};
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]  = cnt_q[c];
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            rdat_d[c] = rdat_q[c];

            pop_ok_s[c]  = bus.rd_en[c] && (cnt_q[c] != {CW{1'b0}});
            // A full channel still accepts a push when a pop frees a slot the same edge.
            push_ok_s[c] = bus.wr_en[c] && ((cnt_q[c] != CW'(DEPTH)) || pop_ok_s[c]);
            level_s[c]   = (cnt_q[c] >= CW'(THRESH));

            if (push_ok_s[c]) begin
                wptr_d[c] = wptr_q[c] + AW'(1);
            end else begin
                wptr_d[c] = wptr_q[c];
            end

            if (pop_ok_s[c]) begin
                rptr_d[c] = rptr_q[c] + AW'(1);
                rdat_d[c] = mem_q[c][rptr_q[c]];
                rvld_d[c] = 1'b1;
            end else begin
                rvld_d[c] = 1'b0;
            end

            case ({push_ok_s[c], pop_ok_s[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase

            // Error set has priority over a same-cycle clear.
            if (bus.wr_en[c] && !push_ok_s[c]) begin
                ovf_d[c] = 1'b1;
            end else if (bus.err_clr[c]) begin
                ovf_d[c] = 1'b0;
            end else begin
                ovf_d[c] = ovf_q[c];
            end

            if (bus.rd_en[c] && !pop_ok_s[c]) begin
                unf_d[c] = 1'b1;
            end else if (bus.err_clr[c]) begin
                unf_d[c] = 1'b0;
            end else begin
                unf_d[c] = unf_q[c];
            end
        end
        irq_d = |(level_s & bus.irq_mask);
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= {CW{1'b0}};
                wptr_q[c] <= {AW{1'b0}};
                rptr_q[c] <= {AW{1'b0}};
                rdat_q[c] <= {WIDTH{1'b0}};
            end
            rvld_q <= {CHANNELS{1'b0}};
            ovf_q  <= {CHANNELS{1'b0}};
            unf_q  <= {CHANNELS{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c]  <= cnt_d[c];
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                rdat_q[c] <= rdat_d[c];
            end
            rvld_q <= rvld_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            irq_q  <= irq_d;
        end
    end

    // Message storage: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push_ok_s[c]) begin
                mem_q[c][wptr_q[c]] <= bus.wr_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Output packing; full/empty/count derive directly from the count register.
    always_comb begin
        bus.rd_data = {(CHANNELS*WIDTH){1'b0}};
        bus.count   = {(CHANNELS*CW){1'b0}};
        bus.full    = {CHANNELS{1'b0}};
        bus.empty   = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            bus.rd_data[c*WIDTH +: WIDTH] = rdat_q[c];
            bus.count[c*CW +: CW]         = cnt_q[c];
            bus.full[c]                   = (cnt_q[c] == CW'(DEPTH));
            bus.empty[c]                  = (cnt_q[c] == {CW{1'b0}});
        end
        bus.rd_valid = rvld_q;
        bus.err_ovf  = ovf_q;
        bus.err_unf  = unf_q;
        bus.irq      = irq_q;
    end
endmodule

// File: tb/tb_useq_mbox.sv
module tb_useq_mbox;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CH    = 4;
    localparam int THR   = DEPTH / 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    useq_mbox_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CH)) bus ();

    useq_mbox #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CH), .THRESH(THR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per channel plus expected registered outputs.
    logic [WIDTH-1:0] mq [CH][$];
    logic [WIDTH-1:0] exp_data [CH];
    logic [CH-1:0]    exp_valid;
    logic [CH-1:0]    exp_ovf;
    logic [CH-1:0]    exp_unf;
    logic             exp_irq;

    function automatic logic [CW-1:0] dut_cnt(input int c);
        return bus.count[c*CW +: CW];
    endfunction

    function automatic logic [WIDTH-1:0] dut_dat(input int c);
        return bus.rd_data[c*WIDTH +: WIDTH];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            exp_data[c] = '0;
        end
        exp_valid = '0;
        exp_ovf   = '0;
        exp_unf   = '0;
        exp_irq   = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, clock, sample 1 ns later.
    task automatic step(input logic [CH-1:0] we, input logic [CH*WIDTH-1:0] wd,
                        input logic [CH-1:0] re, input logic [CH-1:0] clr);
        bit   pop;
        bit   push;
        logic nirq;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.err_clr = clr;
        nirq = 1'b0;
        for (int c = 0; c < CH; c++)
            if (bus.irq_mask[c] && mq[c].size() >= THR) nirq = 1'b1;
        for (int c = 0; c < CH; c++) begin
            pop  = re[c] && (mq[c].size() > 0);
            push = we[c] && ((mq[c].size() < DEPTH) || pop);
            if (pop) begin
                exp_data[c]  = mq[c].pop_front();
                exp_valid[c] = 1'b1;
            end else begin
                exp_valid[c] = 1'b0;
            end
            if (re[c] && !pop) exp_unf[c] = 1'b1;
            else if (clr[c])   exp_unf[c] = 1'b0;
            if (we[c] && !push) exp_ovf[c] = 1'b1;
            else if (clr[c])    exp_ovf[c] = 1'b0;
            if (push) mq[c].push_back(wd[c*WIDTH +: WIDTH]);
        end
        exp_irq = nirq;
        @(posedge clk);
        #1;
        bus.wr_en   = '0;
        bus.rd_en   = '0;
        bus.err_clr = '0;
    endtask

    task automatic push1(input int c, input logic [WIDTH-1:0] d);
        logic [CH*WIDTH-1:0] wd;
        wd = '0;
        wd[c*WIDTH +: WIDTH] = d;
        step(CH'(1) << c, wd, '0, '0);
    endtask

    task automatic pop1(input int c);
        step('0, '0, CH'(1) << c, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wr_en = '0; bus.wr_data = '0; bus.rd_en = '0;
        bus.err_clr = '0; bus.irq_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL reset_empty: got %h want %h", bus.empty, 4'hF); end
        checks++; if (bus.full !== 4'h0) begin errors++; $display("FAIL reset_full: got %h want %h", bus.full, 4'h0); end
        checks++; if (bus.count !== 20'h0) begin errors++; $display("FAIL reset_count: got %h want 0", bus.count); end
        checks++; if ({bus.irq, bus.rd_valid, bus.err_ovf, bus.err_unf} !== 13'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", {bus.irq, bus.rd_valid, bus.err_ovf, bus.err_unf}); end
        checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    endtask

    task automatic test_order();
        for (int i = 0; i < 4; i++) push1(0, 8'h11 + 8'(i));
        checks++; if (dut_cnt(0) !== 5'd4) begin errors++; $display("FAIL order_count: got %0d want 4", dut_cnt(0)); end
        for (int i = 0; i < 4; i++) begin
            pop1(0);
            checks++; if (bus.rd_valid !== 4'b0001) begin errors++; $display("FAIL order_valid[%0d]: got %b want 0001", i, bus.rd_valid); end
            checks++; if (dut_dat(0) !== 8'h11 + 8'(i)) begin errors++; $display("FAIL order_data[%0d]: got %h want %h", i, dut_dat(0), 8'h11 + 8'(i)); end
        end
        checks++; if (bus.empty !== 4'hF) begin errors++; $display("FAIL order_empty: got %h want F", bus.empty); end
    endtask

    task automatic test_fill_wrap();
        logic [WIDTH-1:0] vals [DEPTH];
        // Advance the pointers first so the fill crosses the wrap point.
        for (int i = 0; i < 5; i++) push1(2, 8'($urandom));
        for (int i = 0; i < 5; i++) pop1(2);
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 8'($urandom);
            push1(2, vals[i]);
        end
        checks++; if (bus.full !== 4'b0100) begin errors++; $display("FAIL fill_full: got %b want 0100", bus.full); end
        checks++; if (dut_cnt(2) !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", dut_cnt(2)); end
        push1(2, 8'hEE);
        checks++; if (bus.err_ovf !== 4'b0100) begin errors++; $display("FAIL fill_ovf: got %b want 0100", bus.err_ovf); end
        checks++; if (dut_cnt(2) !== 5'd16) begin errors++; $display("FAIL fill_ovf_count: got %0d want 16", dut_cnt(2)); end
        for (int i = 0; i < DEPTH; i++) begin
            pop1(2);
            checks++; if (dut_dat(2) !== vals[i] || bus.rd_valid[2] !== 1'b1) begin errors++; $display("FAIL wrap_data[%0d]: got %h/%b want %h/1", i, dut_dat(2), bus.rd_valid[2], vals[i]); end
        end
        checks++; if (bus.empty[2] !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty[2]); end
        step('0, '0, '0, 4'b0100);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) push1(1, 8'h40 + 8'(i));
        step(4'b0010, 32'h0000_AA00, 4'b0010, '0);
        checks++; if (dut_cnt(1) !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d want 16", dut_cnt(1)); end
        checks++; if (dut_dat(1) !== 8'h40 || bus.rd_valid[1] !== 1'b1) begin errors++; $display("FAIL fpp_oldest: got %h/%b want 40/1", dut_dat(1), bus.rd_valid[1]); end
        checks++; if (bus.err_ovf[1] !== 1'b0) begin errors++; $display("FAIL fpp_no_ovf: got %b want 0", bus.err_ovf[1]); end
        for (int i = 1; i <= DEPTH; i++) begin
            pop1(1);
            checks++; if (dut_dat(1) !== ((i == DEPTH) ? 8'hAA : 8'h40 + 8'(i))) begin errors++; $display("FAIL fpp_drain[%0d]: got %h want %h", i, dut_dat(1), (i == DEPTH) ? 8'hAA : 8'h40 + 8'(i)); end
        end
        step(4'b1000, 32'h3300_0000, 4'b1000, '0);
        checks++; if (dut_cnt(3) !== 5'd1) begin errors++; $display("FAIL epp_count: got %0d want 1", dut_cnt(3)); end
        checks++; if (bus.err_unf[3] !== 1'b1) begin errors++; $display("FAIL epp_unf: got %b want 1", bus.err_unf[3]); end
        checks++; if (bus.rd_valid[3] !== 1'b0) begin errors++; $display("FAIL epp_valid: got %b want 0", bus.rd_valid[3]); end
        pop1(3);
        checks++; if (dut_dat(3) !== 8'h33) begin errors++; $display("FAIL epp_data: got %h want 33", dut_dat(3)); end
        step('0, '0, '0, 4'b1000);
    endtask

    task automatic test_irq();
        bus.irq_mask = 4'b0001;
        for (int i = 0; i < THR; i++) push1(0, 8'(i));
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want 0", bus.irq); end
        step('0, '0, '0, '0);
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", bus.irq); end
        pop1(0);
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", bus.irq); end
        step('0, '0, '0, '0);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", bus.irq); end
        while (mq[0].size() > 0) pop1(0);
        for (int i = 0; i < THR; i++) push1(1, 8'(i));
        step('0, '0, '0, '0);
        step('0, '0, '0, '0);
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", bus.irq); end
        while (mq[1].size() > 0) pop1(1);
        bus.irq_mask = '0;
    endtask

    task automatic test_err_clr();
        pop1(0);
        checks++; if (bus.err_unf[0] !== 1'b1) begin errors++; $display("FAIL clr_set: got %b want 1", bus.err_unf[0]); end
        step('0, '0, '0, 4'b0001);
        checks++; if (bus.err_unf[0] !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", bus.err_unf[0]); end
        step('0, '0, 4'b0001, 4'b0001);
        checks++; if (bus.err_unf[0] !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b want 1", bus.err_unf[0]); end
        step('0, '0, '0, 4'b0001);
    endtask

    task automatic test_async_reset();
        bus.irq_mask = 4'b0001;
        for (int i = 0; i < 5; i++) push1(0, 8'h60 + 8'(i));
        pop1(2);
        checks++; if (dut_cnt(0) !== 5'd5) begin errors++; $display("FAIL ar_pre_count: got %0d want 5", dut_cnt(0)); end
        bus.wr_en = 4'b0001;
        bus.wr_data = 32'h0000_0077;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.count !== 20'h0 || bus.empty !== 4'hF || bus.full !== 4'h0) begin errors++; $display("FAIL ar_status: got cnt=%h empty=%h full=%h want 0/F/0", bus.count, bus.empty, bus.full); end
        checks++; if ({bus.irq, bus.rd_valid, bus.err_ovf, bus.err_unf} !== 13'h0 || bus.rd_data !== 32'h0) begin errors++; $display("FAIL ar_outputs: got %h/%h want 0/0", {bus.irq, bus.rd_valid, bus.err_ovf, bus.err_unf}, bus.rd_data); end
        bus.wr_en = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push1(0, 8'h5A);
        checks++; if (dut_cnt(0) !== 5'd1) begin errors++; $display("FAIL ar_first_push: got %0d want 1", dut_cnt(0)); end
        pop1(0);
        checks++; if (dut_dat(0) !== 8'h5A || bus.rd_valid !== 4'b0001) begin errors++; $display("FAIL ar_first_pop: got %h/%b want 5A/0001", dut_dat(0), bus.rd_valid); end
        bus.irq_mask = '0;
    endtask

    task automatic test_random();
        logic [CH-1:0] we, re, clr;
        int pw, pr;
        for (int n = 0; n < 400; n++) begin
            pw = ((n / 50) % 2 == 0) ? 75 : 25;
            pr = 100 - pw;
            if (n % 20 == 0) bus.irq_mask = 4'($urandom);
            for (int c = 0; c < CH; c++) begin
                we[c]  = ($urandom_range(0, 99) < pw);
                re[c]  = ($urandom_range(0, 99) < pr);
                clr[c] = ($urandom_range(0, 99) < 6);
            end
            step(we, 32'($urandom), re, clr);
            for (int c = 0; c < CH; c++) begin
                checks++; if (dut_cnt(c) !== 5'(mq[c].size())) begin errors++; $display("FAIL rnd_count ch%0d cyc%0d: got %0d want %0d", c, n, dut_cnt(c), mq[c].size()); end
                checks++; if (bus.full[c] !== (mq[c].size() == DEPTH) || bus.empty[c] !== (mq[c].size() == 0)) begin errors++; $display("FAIL rnd_fe ch%0d cyc%0d: got %b%b want size %0d", c, n, bus.full[c], bus.empty[c], mq[c].size()); end
                checks++; if (dut_dat(c) !== exp_data[c]) begin errors++; $display("FAIL rnd_data ch%0d cyc%0d: got %h want %h", c, n, dut_dat(c), exp_data[c]); end
            end
            checks++; if (bus.rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc%0d: got %b want %b", n, bus.rd_valid, exp_valid); end
            checks++; if (bus.err_ovf !== exp_ovf || bus.err_unf !== exp_unf) begin errors++; $display("FAIL rnd_err cyc%0d: got %b/%b want %b/%b", n, bus.err_ovf, bus.err_unf, exp_ovf, exp_unf); end
            checks++; if (bus.irq !== exp_irq) begin errors++; $display("FAIL rnd_irq cyc%0d: got %b want %b", n, bus.irq, exp_irq); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_order();
        test_fill_wrap();
        test_full_push_pop();
        test_irq();
        test_err_clr();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
